// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared sizing types and build-time constants for the FWFT FIFO.
//            PARITY_W is 1 when FIFO_PARITY_EN is defined and 0 otherwise. It
//            widens each RAM entry by one even-parity bit.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Default geometry, used where a fixed-size count type is convenient.
    localparam int DEFAULT_DEPTH = 32;

    // Occupancy count type. It needs one bit more than the address so that
    // it can represent DEPTH itself.
    typedef logic [$clog2(DEFAULT_DEPTH):0] fifo_cnt_t;

`ifdef FIFO_PARITY_EN
    localparam int PARITY_W = 1;
`else
    localparam int PARITY_W = 0;
`endif

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram_2p.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram_2p
// Purpose  : Simple dual-port RAM. It has one synchronous write port and one
//            read port whose output is registered. The read register updates
//            only when rd_en_i is high, so the word stays put until the next
//            read is issued.
// Ports    : clock      - clock
//            wr_en_i    - write enable
//            wr_addr_i  - write address
//            wr_data_i  - write data
//            rd_en_i    - read enable (loads rd_data_o on the next edge)
//            rd_addr_i  - read address
//            rd_data_o  - registered read data
// Revision : 1.0  initial release
// ============================================================================
module fifo_ram_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int c_depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [c_depth];
    logic [DATA_W-1:0] rd_data_q;

    // No reset on the storage. The control logic in the top never presents
    // a word that was not written after the last reset or flush.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : fifo_ram_2p
`default_nettype wire

// File: rtl/fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : fifo_fwft
// Purpose  : Single-clock first-word-fall-through FIFO. It provides runtime
//            almost-full and almost-empty thresholds, an occupancy count,
//            a synchronous flush, and sticky overflow/underflow flags.
//            With FIFO_PARITY_EN defined, each entry carries an even-parity
//            bit. The bit is checked as the word enters the output register,
//            and a mismatch sets the sticky parity_err flag.
// Ports    : clock      - clock
//            rstn       - asynchronous active-low reset
//            flush      - synchronous clear of contents and sticky flags
//            push       - write request, data_in
//            pop        - consume the head word (honoured only while valid)
//            data_out   - head word, meaningful while valid=1
//            valid      - data_out holds a readable word
//            full/empty - count == DEPTH / count == 0
//            alFull     - count >= af_thresh
//            alEmpty    - count <= ae_thresh
//            count      - entries accepted and not yet popped
//            overflow   - sticky: push while full
//            underflow  - sticky: pop while not valid
//            parity_err - sticky parity mismatch (0 without FIFO_PARITY_EN)
// Revision : 1.0  initial release
// ============================================================================
module fifo_fwft
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 push,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 pop,
    output logic [WIDTH-1:0]     data_out,
    output logic                 valid,
    output logic                 full,
    output logic                 alFull,
    output logic                 empty,
    output logic                 alEmpty,
    input  logic [ADDR_BITS:0]   af_thresh,
    input  logic [ADDR_BITS:0]   ae_thresh,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 parity_err
);

    localparam int             CW         = ADDR_BITS + 1;
    localparam int             RAM_W      = WIDTH + PARITY_W;
    localparam logic [CW-1:0]  c_full_cnt = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_BITS-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]        count_q,    count_d;
    logic                 s1_vld_q,   s1_vld_d;     // RAM read register holds a word
    logic                 valid_q,    valid_d;      // output register holds a word
    logic [WIDTH-1:0]     data_out_q, data_out_d;
    logic                 full_q,     full_d;
    logic                 empty_q,    empty_d;
    logic                 alfull_q,   alfull_d;
    logic                 alempty_q,  alempty_d;
    logic                 ovf_q,      ovf_d;
    logic                 unf_q,      unf_d;
    logic [CW-1:0]        af_thr_q;
    logic [CW-1:0]        ae_thr_q;

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_s1_move;
    logic                 w_ram_rd;
    logic [CW-1:0]        w_ram_cnt;
    logic [RAM_W-1:0]     w_ram_wdata;
    logic [RAM_W-1:0]     w_ram_rdata;

    // ------------------------------------------------------------------
    // Handshake decode. Flush suppresses every transfer in its cycle.
    // ------------------------------------------------------------------
    assign w_wr = push & ~full_q & ~flush;
    assign w_rd = pop & valid_q & ~flush;

    // Words still sitting in RAM, not yet fetched into either pipeline
    // register.
    assign w_ram_cnt = count_q - CW'(s1_vld_q) - CW'(valid_q);

    // The read register feeds the output register whenever the output is
    // empty or is being consumed this cycle.
    assign w_s1_move = s1_vld_q & (~valid_q | w_rd) & ~flush;

    // A RAM fetch is issued only for words written on an earlier edge, so a
    // read never targets the address being written in the same cycle. The
    // fetch also requires the read register to be free or emptying.
    assign w_ram_rd = (w_ram_cnt != '0) & (~s1_vld_q | w_s1_move) & ~flush;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        s1_vld_d   = s1_vld_q;
        valid_d    = valid_q;
        data_out_d = data_out_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            s1_vld_d   = 1'b0;
            valid_d    = 1'b0;
            data_out_d = '0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
        end else begin
            if (w_wr) begin
                wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
            end
            if (w_ram_rd) begin
                rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
            end

            if (w_wr && !w_rd) begin
                count_d = count_q + CW'(1);
            end else if (w_rd && !w_wr) begin
                count_d = count_q - CW'(1);
            end

            if (w_ram_rd) begin
                s1_vld_d = 1'b1;
            end else if (w_s1_move) begin
                s1_vld_d = 1'b0;
            end

            if (w_s1_move) begin
                valid_d    = 1'b1;
                data_out_d = w_ram_rdata[WIDTH-1:0];
            end else if (w_rd) begin
                valid_d    = 1'b0;
            end

            if (push && full_q) begin
                ovf_d = 1'b1;
            end
            if (pop && !valid_q) begin
                unf_d = 1'b1;
            end
        end

        // Flags are registered from the next count, so they move on the same
        // edge as count. The thresholds are registered copies: a new threshold
        // shows up on the flags one edge after it is sampled.
        full_d    = (count_d == c_full_cnt);
        empty_d   = (count_d == '0);
        alfull_d  = (count_d >= af_thr_q);
        alempty_d = (count_d <= ae_thr_q);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s1_vld_q   <= 1'b0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            alfull_q   <= 1'b0;
            alempty_q  <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            // Reset values keep alFull low and alEmpty high on the first edge
            // out of reset, before the real thresholds have been sampled.
            af_thr_q   <= c_full_cnt;
            ae_thr_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            s1_vld_q   <= s1_vld_d;
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            alfull_q   <= alfull_d;
            alempty_q  <= alempty_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            af_thr_q   <= af_thresh;
            ae_thr_q   <= ae_thresh;
        end
    end

    // ------------------------------------------------------------------
    // Optional parity
    // ------------------------------------------------------------------
`ifdef FIFO_PARITY_EN
    logic parity_err_q;
    logic parity_err_d;

    assign w_ram_wdata = {^data_in, data_in};

    // Even parity over data plus stored bit: any odd XOR means corruption.
    always_comb begin
        parity_err_d = parity_err_q;
        if (flush) begin
            parity_err_d = 1'b0;
        end else if (w_s1_move && (^w_ram_rdata)) begin
            parity_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign w_ram_wdata = data_in;
    assign parity_err  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fifo_ram_2p #(
        .DATA_W (RAM_W),
        .ADDR_W (ADDR_BITS)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (w_wr),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (w_ram_wdata),
        .rd_en_i   (w_ram_rd),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign alFull    = alfull_q;
    assign alEmpty   = alempty_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule : fifo_fwft
`default_nettype wire

// File: tb/tb_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_fwft
// Purpose  : Directed self-checking bench for fifo_fwft (WIDTH=32, DEPTH=32).
//            The parity-corruption step is built only with FIFO_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_fwft;

    logic        clock = 1'b0;
    logic        rstn;
    logic        flush;
    logic        push;
    logic [31:0] data_in;
    logic        pop;
    logic [31:0] data_out;
    logic        valid;
    logic        full;
    logic        alFull;
    logic        empty;
    logic        alEmpty;
    logic [5:0]  af_thresh;
    logic [5:0]  ae_thresh;
    logic [5:0]  count;
    logic        overflow;
    logic        underflow;
    logic        parity_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    fifo_fwft #(
        .WIDTH (32),
        .DEPTH (32)
    ) u_dut (
        .clock      (clock),
        .rstn       (rstn),
        .flush      (flush),
        .push       (push),
        .data_in    (data_in),
        .pop        (pop),
        .data_out   (data_out),
        .valid      (valid),
        .full       (full),
        .alFull     (alFull),
        .empty      (empty),
        .alEmpty    (alEmpty),
        .af_thresh  (af_thresh),
        .ae_thresh  (ae_thresh),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow),
        .parity_err (parity_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One active edge, then return at the following falling edge where outputs
    // are sampled and new inputs are driven.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        rstn      = 1'b0;
        flush     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        data_in   = 32'd0;
        af_thresh = 6'd28;
        ae_thresh = 6'd4;
        repeat (2) @(negedge clock);

        // Reset state
        chk("rst_valid",     32'(valid),      32'd0);
        chk("rst_data_out",  data_out,        32'd0);
        chk("rst_full",      32'(full),       32'd0);
        chk("rst_alFull",    32'(alFull),     32'd0);
        chk("rst_empty",     32'(empty),      32'd1);
        chk("rst_alEmpty",   32'(alEmpty),    32'd1);
        chk("rst_count",     32'(count),      32'd0);
        chk("rst_overflow",  32'(overflow),   32'd0);
        chk("rst_underflow", 32'(underflow),  32'd0);
        chk("rst_parity",    32'(parity_err), 32'd0);
        rstn = 1'b1;
        tick();
        tick();
        chk("idle_alEmpty",  32'(alEmpty),    32'd1);

        // First-word latency: push at edge 0, visible after edge 2
        push = 1'b1; data_in = 32'hA5;
        tick();
        push = 1'b0; data_in = 32'd0;
        chk("lat_e0_valid",  32'(valid),      32'd0);
        chk("lat_e0_count",  32'(count),      32'd1);
        chk("lat_e0_empty",  32'(empty),      32'd0);
        tick();
        chk("lat_e1_valid",  32'(valid),      32'd0);
        tick();
        chk("lat_e2_valid",  32'(valid),      32'd1);
        chk("lat_e2_data",   data_out,        32'hA5);
        chk("lat_e2_count",  32'(count),      32'd1);
        tick();
        chk("hold_data",     data_out,        32'hA5);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("pop1_valid",    32'(valid),      32'd0);
        chk("pop1_count",    32'(count),      32'd0);
        chk("pop1_empty",    32'(empty),      32'd1);
        chk("pop1_underflow",32'(underflow),  32'd0);

        // Pop while nothing valid
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("unf_flag",      32'(underflow),  32'd1);
        chk("unf_count",     32'(count),      32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("unf_cleared",   32'(underflow),  32'd0);

        // Fill 0..31, watch alFull cross at 28
        for (int i = 0; i < 32; i++) begin
            push = 1'b1; data_in = 32'(i);
            tick();
            if (i == 26) chk("fill_alFull_27", 32'(alFull), 32'd0);
            if (i == 27) chk("fill_alFull_28", 32'(alFull), 32'd1);
            if (i == 30) chk("fill_full_31",   32'(full),   32'd0);
        end
        push = 1'b1; data_in = 32'hFF;
        tick();
        push = 1'b0; data_in = 32'd0;
        chk("ovf_flag",      32'(overflow),   32'd1);
        chk("ovf_count",     32'(count),      32'd32);
        chk("ovf_full",      32'(full),       32'd1);
        chk("ovf_head",      data_out,        32'd0);

        // Drain with pop held: one word per cycle, in order, 0xFF absent
        pop = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("drain_data",    data_out,        32'(i));
            chk("drain_valid",   32'(valid),      32'd1);
            chk("drain_count",   32'(count),      32'(32 - i));
            chk("drain_alEmpty", 32'(alEmpty),    32'((32 - i) <= 4));
            tick();
        end
        pop = 1'b0;
        chk("drained_empty", 32'(empty),      32'd1);
        chk("drained_valid", 32'(valid),      32'd0);
        chk("drained_count", 32'(count),      32'd0);
        chk("ovf_sticky",    32'(overflow),   32'd1);

        // Half full, simultaneous push/pop for 100 cycles
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ovf",     32'(overflow),   32'd0);
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; data_in = 32'(100 + i);
            tick();
        end
        push = 1'b0;
        tick();
        tick();
        chk("half_count",    32'(count),      32'd16);
        chk("half_alFull",   32'(alFull),     32'd0);
        chk("half_alEmpty",  32'(alEmpty),    32'd0);
        push = 1'b1; pop = 1'b1;
        for (int j = 0; j < 100; j++) begin
            data_in = 32'(200 + j);
            chk("stream_data",  data_out,   (j < 16) ? 32'(100 + j) : 32'(184 + j));
            chk("stream_count", 32'(count), 32'd16);
            tick();
        end
        push = 1'b0; pop = 1'b0;
        chk("stream_end_count", 32'(count), 32'd16);
        chk("stream_end_head",  data_out,   32'd284);

        // Flush at count 10 with overflow set
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 33; i++) begin
            push = 1'b1; data_in = 32'(300 + i);
            tick();
        end
        push = 1'b0;
        pop = 1'b1;
        repeat (22) tick();
        pop = 1'b0;
        chk("pre_flush_count", 32'(count),    32'd10);
        chk("pre_flush_ovf",   32'(overflow), 32'd1);
        chk("pre_flush_head",  data_out,      32'd322);
        flush = 1'b1; push = 1'b1; pop = 1'b1; data_in = 32'hDEAD;
        tick();
        flush = 1'b0; push = 1'b0; pop = 1'b0; data_in = 32'd0;
        chk("flush_count",   32'(count),      32'd0);
        chk("flush_valid",   32'(valid),      32'd0);
        chk("flush_ovf2",    32'(overflow),   32'd0);
        chk("flush_unf",     32'(underflow),  32'd0);
        chk("flush_data",    data_out,        32'd0);
        chk("flush_empty",   32'(empty),      32'd1);
        chk("flush_full",    32'(full),       32'd0);
        tick();
        chk("flush_ign_count", 32'(count),    32'd0);
        chk("flush_ign_valid", 32'(valid),    32'd0);

        // Runtime threshold change
        for (int i = 1; i <= 3; i++) begin
            push = 1'b1; data_in = 32'(i);
            tick();
        end
        push = 1'b0;
        tick();
        chk("thr_alFull_28",  32'(alFull),    32'd0);
        af_thresh = 6'd2;
        tick();
        tick();
        chk("thr_alFull_2",   32'(alFull),    32'd1);
        af_thresh = 6'd28; ae_thresh = 6'd3;
        tick();
        tick();
        chk("thr_alFull_back",32'(alFull),    32'd0);
        chk("thr_alEmpty_3",  32'(alEmpty),   32'd1);
        ae_thresh = 6'd2;
        tick();
        tick();
        chk("thr_alEmpty_2",  32'(alEmpty),   32'd0);
        ae_thresh = 6'd4;

        // Asynchronous reset mid-operation, away from any clock edge
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_count",    32'(count),      32'd0);
        chk("arst_valid",    32'(valid),      32'd0);
        chk("arst_empty",    32'(empty),      32'd1);
        @(negedge clock);
        rstn = 1'b1;
        tick();
        push = 1'b1; data_in = 32'h77;
        tick();
        push = 1'b0; data_in = 32'd0;
        tick();
        tick();
        chk("arst_new_data", data_out,        32'h77);
        chk("arst_new_count",32'(count),      32'd1);

`ifdef FIFO_PARITY_EN
        // 0x77 sits in the output, 0x11 in the read register, 0x22 in RAM slot 2
        push = 1'b1; data_in = 32'h11;
        tick();
        data_in = 32'h22;
        tick();
        push = 1'b0;
        tick();
        u_dut.u_ram.mem_q[2] = u_dut.u_ram.mem_q[2] ^ 33'd1;
        chk("par_before",    32'(parity_err), 32'd0);
        pop = 1'b1;
        tick();
        chk("par_mid",       32'(parity_err), 32'd0);
        tick();
        pop = 1'b0;
        chk("par_after",     32'(parity_err), 32'd1);
`else
        chk("par_tied_low",  32'(parity_err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_fifo_fwft
`default_nettype wire
